// File: rtl/normalize_left.sv
// normalize_left: post-add left normalizer with valid/ready handshake on both sides.
// Define NORM_FAST_LZC_EN to resolve the whole shift in one cycle via a leading-zero count.
module normalize_left #(
    parameter int FRAC_W = 32,
    parameter int EXP_W = 8,
    parameter int CNT_W = $clog2(FRAC_W) + 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              inValid,
    output logic              inReady,
    input  logic [FRAC_W-1:0] inFrac,
    input  logic [EXP_W-1:0]  inExp,
    output logic              outValid,
    input  logic              outReady,
    output logic [FRAC_W-1:0] outFrac,
    output logic [EXP_W-1:0]  outExp,
    output logic [CNT_W-1:0]  shiftCount,
    output logic              zeroFlag,
    output logic              denormFlag
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;
    stateT state;

    assign inReady = (state == IDLE);

`ifdef NORM_FAST_LZC_EN
    localparam int MW = (EXP_W > CNT_W) ? EXP_W : CNT_W;
    logic [CNT_W-1:0] lzc;
    logic [CNT_W-1:0] amt;
    logic             lzcGt;
    always_comb begin
        lzc = CNT_W'(FRAC_W);
        for (int i = 0; i < FRAC_W; i++)
            if (outFrac[i]) lzc = CNT_W'(FRAC_W - 1 - i);
        lzcGt = MW'(lzc) > MW'(outExp);
        amt = lzcGt ? CNT_W'(outExp) : lzc;
    end
`endif

    // Working registers double as the output registers; they only move outside DONE.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            outValid   <= 1'b0;
            outFrac    <= '0;
            outExp     <= '0;
            shiftCount <= '0;
            zeroFlag   <= 1'b0;
            denormFlag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (inValid) begin
                    state      <= SHIFT;
                    outFrac    <= inFrac;
                    outExp     <= inExp;
                    shiftCount <= '0;
                    zeroFlag   <= 1'b0;
                    denormFlag <= 1'b0;
                end
`ifdef NORM_FAST_LZC_EN
                SHIFT: begin
                    state    <= DONE;
                    outValid <= 1'b1;
                    if (outFrac == '0) begin
                        zeroFlag <= 1'b1;
                        outExp   <= '0;
                    end else begin
                        outFrac    <= outFrac << amt;
                        outExp     <= outExp - EXP_W'(amt);
                        shiftCount <= amt;
                        denormFlag <= lzcGt;
                    end
                end
`else
                SHIFT: if (outFrac == '0) begin
                    zeroFlag <= 1'b1;
                    outExp   <= '0;
                    state    <= DONE;
                    outValid <= 1'b1;
                end else if (outFrac[FRAC_W-1]) begin
                    state    <= DONE;
                    outValid <= 1'b1;
                end else if (outExp == '0) begin
                    denormFlag <= 1'b1;
                    state      <= DONE;
                    outValid   <= 1'b1;
                end else begin
                    outFrac    <= outFrac << 1;
                    outExp     <= outExp - EXP_W'(1);
                    shiftCount <= shiftCount + CNT_W'(1);
                end
`endif
                DONE: if (outReady) begin
                    state    <= IDLE;
                    outValid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_normalize_left.sv
// tb_normalize_left: table vectors, corner sequences and random operands vs a reference model.
module tb_normalize_left;
    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] inFrac = '0;
    logic [7:0]  inExp = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] outFrac;
    logic [7:0]  outExp;
    logic [5:0]  shiftCount;
    logic        zeroFlag;
    logic        denormFlag;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] frac;
        logic [7:0]  exp;
        logic [31:0] eFrac;
        logic [7:0]  eExp;
        int          eCnt;
        logic        eZero;
        logic        eDen;
    } vecT;
    vecT vecs[8];

    normalize_left dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
        .inFrac(inFrac), .inExp(inExp), .outValid(outValid), .outReady(outReady),
        .outFrac(outFrac), .outExp(outExp), .shiftCount(shiftCount),
        .zeroFlag(zeroFlag), .denormFlag(denormFlag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: shift left while MSB clear and exponent remains; zero is special.
    function automatic void model(input logic [31:0] f, input logic [7:0] e,
                                  output logic [31:0] rf, output logic [7:0] re,
                                  output int k, output logic z, output logic d);
        rf = f; re = e; k = 0; z = 1'b0; d = 1'b0;
        if (f == 0) begin
            re = 0; z = 1'b1;
        end else begin
            while (!rf[31] && re > 0) begin
                rf = rf * 2; re = re - 1; k = k + 1;
            end
            d = !rf[31];
        end
    endfunction

    task automatic checkOut(input string tag, input logic [31:0] eFrac, input logic [7:0] eExp,
                            input int eCnt, input logic eZero, input logic eDen);
        chk({tag, ".outFrac"}, 64'(outFrac), 64'(eFrac));
        chk({tag, ".outExp"}, 64'(outExp), 64'(eExp));
        chk({tag, ".shiftCount"}, 64'(shiftCount), 64'(eCnt));
        chk({tag, ".zeroFlag"}, 64'(zeroFlag), 64'(eZero));
        chk({tag, ".denormFlag"}, 64'(denormFlag), 64'(eDen));
    endtask

    task automatic accept(input logic [31:0] f, input logic [7:0] e);
        @(negedge clk);
        inValid = 1'b1; inFrac = f; inExp = e; outReady = 1'b0;
        @(posedge clk);
        #1 inValid = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [31:0] f, input logic [7:0] e, input int hold);
        logic [31:0] rf; logic [7:0] re; int k; logic z, d; int cyc, lat;
        model(f, e, rf, re, k, z, d);
`ifdef NORM_FAST_LZC_EN
        lat = 1;
`else
        lat = k + 1;
`endif
        chk({tag, ".inReadyIdle"}, 64'(inReady), 64'(1));
        accept(f, e);
        cyc = 0;
        while (!outValid && cyc < 100) begin
            @(posedge clk); #1 cyc++;
        end
        chk({tag, ".latency"}, 64'(cyc), 64'(lat));
        checkOut(tag, rf, re, k, z, d);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".holdValid"}, 64'(outValid), 64'(1));
            chk({tag, ".holdInReady"}, 64'(inReady), 64'(0));
            checkOut({tag, ".hold"}, rf, re, k, z, d);
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        chk({tag, ".postValid"}, 64'(outValid), 64'(0));
        chk({tag, ".postInReady"}, 64'(inReady), 64'(1));
    endtask

    initial begin
        vecs[0] = '{32'h80000001, 8'd100, 32'h80000001, 8'd100, 0, 1'b0, 1'b0};
        vecs[1] = '{32'h00400000, 8'd10, 32'h80000000, 8'd1, 9, 1'b0, 1'b0};
        vecs[2] = '{32'h00000100, 8'd5, 32'h00002000, 8'd0, 5, 1'b0, 1'b1};
        vecs[3] = '{32'h00000000, 8'd77, 32'h00000000, 8'd0, 0, 1'b1, 1'b0};
        vecs[4] = '{32'h00000001, 8'd255, 32'h80000000, 8'd224, 31, 1'b0, 1'b0};
        vecs[5] = '{32'h00000001, 8'd31, 32'h80000000, 8'd0, 31, 1'b0, 1'b0};
        vecs[6] = '{32'h40000000, 8'd0, 32'h40000000, 8'd0, 0, 1'b0, 1'b1};
        vecs[7] = '{32'h80000000, 8'd0, 32'h80000000, 8'd0, 0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.outValid", 64'(outValid), 64'(0));
        chk("reset.inReady", 64'(inReady), 64'(1));
        checkOut("reset", 32'h0, 8'h0, 0, 1'b0, 1'b0);
        @(negedge clk) rstN = 1'b1;

        // Fixed table: the bench model must agree with the hand-derived expectations too.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] rf; logic [7:0] re; int k; logic z, d;
            model(vecs[i].frac, vecs[i].exp, rf, re, k, z, d);
            chk($sformatf("vec%0d.model", i), {rf, re, 8'(k), 7'd0, z, d},
                {vecs[i].eFrac, vecs[i].eExp, 8'(vecs[i].eCnt), 7'd0, vecs[i].eZero, vecs[i].eDen});
            runOp($sformatf("vec%0d", i), vecs[i].frac, vecs[i].exp, 0);
        end

        runOp("backpressure", 32'h00400000, 8'd10, 5);

        // Async reset three cycles into a shift discards the operation.
        accept(32'h00400000, 8'd10);
        repeat (3) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("midReset.outValid", 64'(outValid), 64'(0));
        chk("midReset.inReady", 64'(inReady), 64'(1));
        checkOut("midReset", 32'h0, 8'h0, 0, 1'b0, 1'b0);
        @(negedge clk) rstN = 1'b1;
        runOp("afterReset", 32'h00400000, 8'd10, 1);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] f; logic [7:0] e;
            f = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) f = 32'h0;
            e = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
            runOp($sformatf("rand%0d", n), f, e, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/normalize_left.md
# normalize_left

Post-add normalizer for the floating-point adder datapath: the left-shift counterpart of the exponent-alignment right shifter. It accepts an unnormalized fraction and exponent from the add/subtract stage. It shifts the fraction left until its MSB is set, decrementing the exponent once per bit shifted. It stops early on a zero fraction or on exponent exhaustion. A valid/ready handshake sits on both sides so the rounding/pack stage can stall it.

## Interface
- FRAC_W, 32, fraction width; normalized means bit FRAC_W-1 = 1
- EXP_W, 8, exponent width (unsigned, biased)
- CNT_W, $clog2(FRAC_W)+1, width of shiftCount
- clk  input  1  clock, all state on rising edge
- rstN  input  1  asynchronous, active-low reset
- inValid  input  1  upstream offers inFrac/inExp
- inReady  output  1  block can accept; high only in IDLE
- inFrac  input  FRAC_W  unnormalized fraction
- inExp  input  EXP_W  exponent of inFrac
- outValid  output  1  result registers hold a completed result
- outReady  input  1  downstream accepts result
- outFrac  output  FRAC_W  normalized (or partially normalized) fraction
- outExp  output  EXP_W  adjusted exponent
- shiftCount  output  CNT_W  total left shift applied
- zeroFlag  output  1  inFrac was zero
- denormFlag  output  1  stopped because exponent reached 0 with MSB still clear

## Operation
- Clock/reset decided: one clock, clk; reset rstN is asynchronous, active-low.
- States: IDLE, SHIFT, DONE.
- IDLE: inReady=1. When inValid=1, capture inFrac/inExp into working registers, clear the count and flags, and go to SHIFT.
- SHIFT: one decision per cycle, in priority order:
  - frac==0: set zeroFlag, force exp to 0, go to DONE.
  - frac[FRAC_W-1]==1: go to DONE.
  - exp==0: set denormFlag, go to DONE.
  - Otherwise: frac<<=1 (zero fill), exp-=1, count+=1, stay in SHIFT.
- Arithmetic range: exp never wraps below 0. count never exceeds FRAC_W-1.
- DONE: outValid=1. Outputs are stable and must not change while outValid=1 && outReady=0. On outReady=1, go to IDLE.
- No input bypass: a new operand is accepted only in the cycle after the DONE handshake.
- Reset values: state=IDLE, inReady=1 (combinational from IDLE), outValid=0, outFrac=0, outExp=0, shiftCount=0, zeroFlag=0, denormFlag=0.
- Reset asserted mid-SHIFT or mid-DONE: the operation is discarded and no output is produced. The block returns to IDLE immediately and asynchronously.

## Timing
- Accept edge: the first edge with inValid && inReady.
- Iterative mode: for a result with k shifts, outValid rises k+1 cycles after the accept edge.
  - Already-normalized or zero input: k=0, latency 1.
  - Worst case: FRAC_W cycles.
- The output handshake completes on the edge where outValid && outReady.
  - inReady is high in the following cycle.
  - Minimum initiation interval is k+3 cycles.
- inReady does not depend combinationally on outReady.

## Configuration
- NORM_FAST_LZC_EN defined:
  - SHIFT resolves in exactly one cycle using a combinational leading-zero count lzc.
  - Shift amount = min(lzc, exp). denormFlag = (lzc > exp) && frac≠0. The zero rule is unchanged.
  - outValid always rises 1 cycle after the accept edge.
  - Every output value is bit-identical to iterative mode.
- NORM_FAST_LZC_EN undefined: the iterative one-bit-per-cycle shifter described above is the only datapath.

## Test plan
- Normalized input: inFrac=0x80000001, inExp=100.
  - Response: outFrac=0x80000001, outExp=100, shiftCount=0, flags 0, outValid 1 cycle after accept.
- Normal shift: inFrac=0x00400000, inExp=10.
  - Response: outFrac=0x80000000, outExp=1, shiftCount=9, flags 0.
  - Latency 10 (iterative), 1 (NORM_FAST_LZC_EN).
- Exponent exhaustion: inFrac=0x00000100, inExp=5.
  - Response: outFrac=0x00002000, outExp=0, shiftCount=5, denormFlag=1.
- Zero: inFrac=0, inExp=77.
  - Response: outFrac=0, outExp=0, shiftCount=0, zeroFlag=1, latency 1.
- Backpressure: run the normal-shift case with outReady=0 for 5 cycles after outValid.
  - All outputs hold and inReady stays 0.
  - Raise outReady: handshake completes and inReady=1 the next cycle.
- Reset mid-shift: on the normal-shift case, pull rstN low 3 cycles after accept.
  - Immediately: outValid=0, all outputs 0, inReady=1.
  - After release, a new operand completes correctly.
